rom_boot_loader: RTL and testbench
==================================

# rom_boot_loader

Boot-time ROM loader between an external byte stream and the instruction ROM. After reset it holds the Core in reset, receives a length-prefixed program image one byte per handshake, and writes it word-by-word into ROM through the ROM write port. After the load completes it hands the ROM port to the Core and releases the Core.

## Interface
- BASE_ADDR, 32'h0000_0000, ROM byte address of the first loaded word
- MAX_WORDS, 1024, largest accepted image length in words (ROM depth)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- reload  in  1  single-cycle pulse: restart loading from DONE or ERR
- in_valid  in  1  byte-stream data valid
- in_data  in  8  byte-stream data
- in_ready  out  1  loader accepts a byte this cycle
- core_rom_en  in  1  Core ROM enable (passthrough source)
- core_rom_write_en  in  `MEM_SEL_BUS (4)  Core ROM byte write enables
- core_rom_addr  in  `ADDR_BUS (32)  Core ROM address
- core_rom_write_data  in  `DATA_BUS (32)  Core ROM write data
- rom_en  out  1  ROM enable
- rom_write_en  out  `MEM_SEL_BUS (4)  ROM byte write enables
- rom_addr  out  `ADDR_BUS (32)  ROM byte address
- rom_write_data  out  `DATA_BUS (32)  ROM write data
- cpu_rst  out  1  reset to Core; high while loading or in error
- load_done  out  1  image loaded, Core running
- load_error  out  1  image length rejected
- words_loaded  out  16  count of words written this load

ROM read data goes from ROM to Core directly, not through this block.

## Operation
- States: HDR, CHECK, DATA, WRITE, DONE, ERR. Reset enters HDR.
- Byte accepted when in_valid && in_ready. in_ready = 1 only in HDR and DATA, and is forced to 0 while rst is high.
- HDR: collect 4 bytes into the word count N, little-endian. The 4th byte moves the FSM to CHECK.
- CHECK, one cycle:
  - N == 0 → DONE.
  - N > MAX_WORDS → ERR.
  - Otherwise → DATA with word index 0.
- DATA: collect 4 bytes little-endian into the word register. The 4th byte moves the FSM to WRITE.
- WRITE, one cycle: rom_en = 1, rom_write_en = 4'hF, rom_addr = BASE_ADDR + 4*idx, rom_write_data = word register. Then idx and words_loaded increment. If the new idx == N → DONE, else → DATA.
- DONE: load_done = 1, cpu_rst = 0, rom_* = core_rom_* (combinational passthrough).
- ERR: load_error = 1, cpu_rst = 1, rom_en = 0, in_ready = 0.
- reload in DONE or ERR → HDR. Byte counter, idx, words_loaded, load_done and load_error clear; cpu_rst goes high. reload in any other state is ignored.
- In every state except DONE and WRITE: rom_en = 0, rom_write_en = 0.
- Arithmetic:
  - Byte counter is 2 bits and wraps 3→0.
  - The N compare uses all 32 bits.
  - The address is computed as 32 bits, with overflow ignored.

## Timing
- Reset values: state HDR, in_ready 0 (during rst), rom_en 0, rom_write_en 0, rom_addr 0, rom_write_data 0, cpu_rst 1, load_done 0, load_error 0, words_loaded 0.
- Accepts at most 1 byte per cycle. Each word costs 4 accepted bytes plus 1 WRITE cycle in which in_ready = 0.
- A ROM write occurs in the cycle after the 4th data byte is accepted.
- After the last WRITE, DONE is entered on the next edge. cpu_rst falls and load_done rises in that same cycle.
- in_valid gaps stall the FSM with no side effects. in_data is ignored when in_valid = 0.
- rst during any state returns to HDR on the next edge. Any partial word is discarded. Words already written stay in ROM.
- reload and rst high together: rst wins.

## Structure
- Shared package / defines header: `ADDR_BUS, `DATA_BUS, `MEM_SEL_BUS, and the state encoding constants.
- One natural sub-module: byte_assembler. It holds the 2-bit counter and the 32-bit little-endian shift register, and outputs word_valid. HDR and DATA both use it.
- The ROM port mux stays in this block.

## Test plan
- Frame 02 00 00 00 44 33 22 11 DD CC BB AA → two writes: addr 0x0 data 0x11223344, then addr 0x4 data 0xAABBCCDD, each with write_en 4'hF. Then load_done = 1, cpu_rst = 0, words_loaded = 2.
- Frame 00 00 00 00 → no ROM write. DONE is reached 1 cycle after CHECK.
- Frame 01 04 00 00 (N = 1025) → load_error = 1, cpu_rst stays 1, in_ready = 0. Later bytes produce no write.
- Scenario 1 replayed with random in_valid gaps of 0–5 cycles → identical writes and final status.
- rst pulsed after 2 data bytes of word 0 → no write occurs. A fresh frame 01 00 00 00 78 56 34 12 writes 0x12345678 at 0x0.
- In DONE with core_rom_addr = 0x8 and core_rom_en = 1 → rom_addr = 0x8 and rom_en = 1 in the same cycle. reload then → cpu_rst = 1 and in_ready = 1 on the next cycle.

Source files
------------

// File: rtl/rom_boot_loader_pkg.sv
// Shared bus widths and FSM state encoding for the boot-time ROM loader.
package rom_boot_loader_pkg;

    localparam int ADDR_BUS    = 32;
    localparam int DATA_BUS    = 32;
    localparam int MEM_SEL_BUS = 4;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_CHECK = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/rom_boot_loader_byte_assembler.sv
// Packs four accepted bytes into a little-endian 32-bit word; used for both
// the length header and the data words.
module rom_boot_loader_byte_assembler
    import rom_boot_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                take,
    input  logic [7:0]          data,
    output logic [DATA_BUS-1:0] word,
    output logic                word_valid
);

    logic [1:0] cnt;

    // NOTE: sequential state is written with <= only, so every flop samples
    // the pre-edge values of its neighbours regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= 2'd0;
            word <= '0;
        end else if (take) begin
            cnt  <= cnt + 2'd1;
            word <= {data, word[DATA_BUS-1:8]};
        end
    end

    // Pulses together with the fourth byte; the word is complete after that edge.
    assign word_valid = take && (cnt == 2'd3);

endmodule

// File: rtl/rom_boot_loader.sv
// Boot loader: holds the Core in reset, streams a length-prefixed image into
// ROM, then hands the ROM port to the Core.
module rom_boot_loader
    import rom_boot_loader_pkg::*;
#(
    parameter logic [ADDR_BUS-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                  MAX_WORDS = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reload,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    input  logic                   core_rom_en,
    input  logic [MEM_SEL_BUS-1:0] core_rom_write_en,
    input  logic [ADDR_BUS-1:0]    core_rom_addr,
    input  logic [DATA_BUS-1:0]    core_rom_write_data,
    output logic                   rom_en,
    output logic [MEM_SEL_BUS-1:0] rom_write_en,
    output logic [ADDR_BUS-1:0]    rom_addr,
    output logic [DATA_BUS-1:0]    rom_write_data,
    output logic                   cpu_rst,
    output logic                   load_done,
    output logic                   load_error,
    output logic [15:0]            words_loaded
);

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

    state_t              state;
    logic [31:0]         n_words;
    logic [DATA_BUS-1:0] asm_word;
    logic                word_valid;
    logic                take;
    logic                restart;
    logic [31:0]         next_idx;

    assign in_ready = !rst && (state == ST_HDR || state == ST_DATA);
    assign take     = in_valid && in_ready;
    assign restart  = reload && (state == ST_DONE || state == ST_ERR);
    assign next_idx = 32'(words_loaded) + 32'd1;

    rom_boot_loader_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (restart),
        .take       (take),
        .data       (in_data),
        .word       (asm_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_HDR;
            n_words      <= '0;
            cpu_rst      <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
        end else begin
            case (state)
                ST_HDR: if (word_valid) state <= ST_CHECK;
                ST_CHECK: begin
                    n_words      <= asm_word;
                    words_loaded <= '0;
                    if (asm_word == 32'd0) begin
                        state     <= ST_DONE;
                        cpu_rst   <= 1'b0;
                        load_done <= 1'b1;
                    end else if (asm_word > MAX_N) begin
                        state      <= ST_ERR;
                        load_error <= 1'b1;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: if (word_valid) state <= ST_WRITE;
                ST_WRITE: begin
                    words_loaded <= words_loaded + 16'd1;
                    if (next_idx == n_words) begin
                        state     <= ST_DONE;
                        cpu_rst   <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        state <= ST_DATA;
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (reload) begin
                        state        <= ST_HDR;
                        cpu_rst      <= 1'b1;
                        load_done    <= 1'b0;
                        load_error   <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                default: state <= ST_HDR;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rom_en         = 1'b0;
        rom_write_en   = '0;
        rom_addr       = '0;
        rom_write_data = '0;
        case (state)
            ST_WRITE: begin
                rom_en         = 1'b1;
                rom_write_en   = '1;
                rom_addr       = BASE_ADDR + {words_loaded, 2'b00};
                rom_write_data = asm_word;
            end
            ST_DONE: begin
                rom_en         = core_rom_en;
                rom_write_en   = core_rom_write_en;
                rom_addr       = core_rom_addr;
                rom_write_data = core_rom_write_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rom_boot_loader.sv
// Directed bench for rom_boot_loader: table of framed images plus hand-written
// sequences for reset abort, CHECK latency, reload and ROM passthrough.
module tb_rom_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reload = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        core_rom_en = 1'b0;
    logic [3:0]  core_rom_write_en = 4'h0;
    logic [31:0] core_rom_addr = 32'h0;
    logic [31:0] core_rom_write_data = 32'h0;
    logic        rom_en;
    logic [3:0]  rom_write_en;
    logic [31:0] rom_addr;
    logic [31:0] rom_write_data;
    logic        cpu_rst;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int total = 0;
    int bad   = 0;

    logic [67:0] wr_q[$];

    always #5 clk = ~clk;

    rom_boot_loader dut (
        .clk                 (clk),
        .rst                 (rst),
        .reload              (reload),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .core_rom_en         (core_rom_en),
        .core_rom_write_en   (core_rom_write_en),
        .core_rom_addr       (core_rom_addr),
        .core_rom_write_data (core_rom_write_data),
        .rom_en              (rom_en),
        .rom_write_en        (rom_write_en),
        .rom_addr            (rom_addr),
        .rom_write_data      (rom_write_data),
        .cpu_rst             (cpu_rst),
        .load_done           (load_done),
        .load_error          (load_error),
        .words_loaded        (words_loaded)
    );

    // Loader-driven ROM writes happen while the Core is still held in reset.
    always @(negedge clk) begin
        if (rom_en && cpu_rst) wr_q.push_back({rom_write_en, rom_addr, rom_write_data});
    end

    typedef struct {
        int          n_bytes;
        logic [95:0] frame;
        int          max_gap;
        logic        exp_done;
        logic        exp_err;
        int          exp_words;
        int          exp_wr;
        logic [31:0] a0, d0, a1, d1;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            in_data = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("byte_accepted", 128'(ok), 128'd1);
    endtask

    task automatic send_frame(input logic [95:0] frame, input int n, input int max_gap);
        for (int i = 0; i < n; i++)
            send_byte(frame[95-8*i -: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        reload   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_state",
              {in_ready, rom_en, rom_write_en, rom_addr, rom_write_data,
               cpu_rst, load_done, load_error, words_loaded},
              {1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0});
        @(posedge clk); #1;
        rst = 1'b0;
        wr_q.delete();
    endtask

    task automatic wait_status();
        bit seen = 0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            seen = load_done || load_error;
        end
        check("status_reached", 128'(seen), 128'd1);
    endtask

    task automatic check_write(input string name, input int k, input logic [31:0] a, input logic [31:0] d);
        if (k < wr_q.size()) check(name, wr_q[k], {4'hF, a, d});
        else check({name, "_present"}, 128'(wr_q.size()), 128'(k + 1));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{12, 96'h02000000_44332211_DDCCBBAA, 0, 1'b1, 1'b0, 2, 2,
                    32'h0, 32'h11223344, 32'h4, 32'hAABBCCDD};
        vecs[1] = '{12, 96'h02000000_44332211_DDCCBBAA, 5, 1'b1, 1'b0, 2, 2,
                    32'h0, 32'h11223344, 32'h4, 32'hAABBCCDD};
        vecs[2] = '{4, 96'h00000000_00000000_00000000, 0, 1'b1, 1'b0, 0, 0,
                    32'h0, 32'h0, 32'h0, 32'h0};
        vecs[3] = '{4, 96'h01040000_00000000_00000000, 0, 1'b0, 1'b1, 0, 0,
                    32'h0, 32'h0, 32'h0, 32'h0};
        vecs[4] = '{4, 96'h01000100_00000000_00000000, 0, 1'b0, 1'b1, 0, 0,
                    32'h0, 32'h0, 32'h0, 32'h0};
        vecs[5] = '{8, 96'h01000000_EFBEADDE_00000000, 2, 1'b1, 1'b0, 1, 1,
                    32'h0, 32'hDEADBEEF, 32'h0, 32'h0};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            send_frame(vecs[v].frame, vecs[v].n_bytes, vecs[v].max_gap);
            wait_status();
            @(negedge clk);
            check($sformatf("v%0d_status", v),
                  {load_done, load_error, cpu_rst, words_loaded},
                  {vecs[v].exp_done, vecs[v].exp_err, ~vecs[v].exp_done, 16'(vecs[v].exp_words)});
            check($sformatf("v%0d_write_count", v), 128'(wr_q.size()), 128'(vecs[v].exp_wr));
            if (vecs[v].exp_wr > 0) check_write($sformatf("v%0d_write0", v), 0, vecs[v].a0, vecs[v].d0);
            if (vecs[v].exp_wr > 1) check_write($sformatf("v%0d_write1", v), 1, vecs[v].a1, vecs[v].d1);
            if (vecs[v].exp_err) begin
                bit any_ready = 0;
                @(posedge clk); #1;
                in_valid = 1'b1;
                for (int t = 0; t < 6; t++) begin
                    in_data = 8'(8'h40 + t);
                    @(negedge clk);
                    any_ready = any_ready | in_ready | rom_en;
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
                check($sformatf("v%0d_err_blocks_input", v), 128'(any_ready), 128'd0);
                check($sformatf("v%0d_err_no_write", v), 128'(wr_q.size()), 128'd0);
                check($sformatf("v%0d_err_holds", v), {load_error, cpu_rst}, 2'b11);
            end
        end

        // rst mid-word discards the partial word; a fresh frame then loads cleanly.
        do_reset();
        send_frame(96'h01000000_7856_0000_00000000, 6, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_in_ready_low", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_write", 128'(wr_q.size()), 128'd0);
        check("abort_back_to_hdr", {in_ready, cpu_rst, words_loaded}, {1'b1, 1'b1, 16'h0});
        @(posedge clk); #1;
        send_frame(96'h01000000_78563412_00000000, 8, 0);
        @(negedge clk);
        check("write_cycle_after_last_byte",
              {rom_en, rom_write_en, rom_addr, rom_write_data, in_ready},
              {1'b1, 4'hF, 32'h0, 32'h12345678, 1'b0});
        @(negedge clk);
        check("done_after_last_write", {load_done, cpu_rst, words_loaded}, {1'b1, 1'b0, 16'd1});

        // Zero-length image: CHECK for one cycle, then DONE.
        do_reset();
        send_frame(96'h00000000_00000000_00000000, 4, 0);
        @(negedge clk);
        check("zero_len_check_cycle", {load_done, cpu_rst}, 2'b01);
        @(negedge clk);
        check("zero_len_done", {load_done, cpu_rst, rom_en}, 3'b100);

        // reload outside DONE/ERR must not disturb the header byte count.
        do_reset();
        send_frame(96'h0100_0000_0000_0000_0000_0000, 2, 0);
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        send_frame(96'h0000_44332211_0000_0000_0000, 6, 0);
        wait_status();
        check("reload_ignored_status", {load_done, words_loaded}, {1'b1, 16'd1});
        check_write("reload_ignored_write", 0, 32'h0, 32'h11223344);

        // DONE passthrough, then reload back to HDR.
        core_rom_en         = 1'b1;
        core_rom_write_en   = 4'h3;
        core_rom_addr       = 32'h8;
        core_rom_write_data = 32'hCAFE_F00D;
        #1;
        check("passthrough", {rom_en, rom_write_en, rom_addr, rom_write_data},
              {1'b1, 4'h3, 32'h8, 32'hCAFE_F00D});
        @(posedge clk); #1;
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        @(negedge clk);
        check("reload_restart", {cpu_rst, in_ready, load_done, words_loaded, rom_en},
              {1'b1, 1'b1, 1'b0, 16'h0, 1'b0});
        core_rom_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
